// File: rtl/sd_three_phase_decoder.sv
// Three-phase sigma-delta decoder.
// Each phase bitstream (1 = +1, 0 = -1) goes through a 2nd-order CIC
// decimator. All three phases share one decimation counter, so their
// samples stay time-aligned. The phase-A samples also feed a rising
// zero-crossing detector, which measures the phase-A period in output
// samples and reports the rotation direction.
module sd_three_phase_decoder #(
    parameter int SD_OUT_BW = 16,
    parameter int DEC_LOG2  = 6,
    parameter int PER_BW    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        bsA,
    input  logic                        bsB,
    input  logic                        bsC,
    output logic signed [SD_OUT_BW-1:0] outA,
    output logic signed [SD_OUT_BW-1:0] outB,
    output logic signed [SD_OUT_BW-1:0] outC,
    output logic                        out_valid,
    output logic [PER_BW-1:0]           period_a,
    output logic                        period_valid,
    output logic                        dir_fwd
);
    // The CIC gain is R**2 = 2**(2*DEC_LOG2), so W bits hold +/-R**2 with
    // room to spare. Modular wrap inside the integrators is harmless
    // because the combs take differences.
    localparam int W      = 2*DEC_LOG2 + 2;
    localparam int SHIFT  = SD_OUT_BW - 1 - 2*DEC_LOG2;
    localparam int EXT_BW = SD_OUT_BW + W;

    localparam logic signed [EXT_BW-1:0] OUT_MAX =
        {{(W+1){1'b0}}, {(SD_OUT_BW-1){1'b1}}};
    localparam logic signed [EXT_BW-1:0] OUT_MIN =
        {{(W+1){1'b1}}, {(SD_OUT_BW-1){1'b0}}};

    // ------------------------------------------------------------------
    // Shared decimation timing
    // ------------------------------------------------------------------
    logic [DEC_LOG2-1:0] dec_cnt_q;
    logic                dec_tick;
    logic                tick_q;

    // R is a power of two, so the tick is simply "counter is all ones".
    assign dec_tick = &dec_cnt_q;

    // Free-running decimation counter; tick_q marks the clk after a tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            dec_cnt_q <= dec_cnt_q + DEC_LOG2'(1);
            tick_q    <= dec_tick;
        end
    end

    // ------------------------------------------------------------------
    // Per-phase CIC decimators (index 0 = A, 1 = B, 2 = C)
    // ------------------------------------------------------------------
    logic [2:0]             bs_vec;
    logic [3*SD_OUT_BW-1:0] sample_flat;

    assign bs_vec = {bsC, bsB, bsA};

    for (genvar gi = 0; gi < 3; gi++) begin : g_phase
        logic signed [W-1:0]         in_pm1;
        logic signed [W-1:0]         int1_q;
        logic signed [W-1:0]         int2_q;
        logic signed [W-1:0]         dly1_q;
        logic signed [W-1:0]         dly2_q;
        logic signed [W-1:0]         comb_q;
        logic signed [W-1:0]         comb1;
        logic signed [W-1:0]         comb2;
        logic signed [EXT_BW-1:0]    comb_ext;
        logic signed [EXT_BW-1:0]    scaled;
        logic signed [SD_OUT_BW-1:0] sample;

        // Map the bit to +1 / -1 in W-bit two's complement.
        assign in_pm1 = bs_vec[gi] ? W'(1) : {W{1'b1}};

        // Comb stages use differential delay 1 at the decimated rate.
        assign comb1 = int2_q - dly1_q;
        assign comb2 = comb1 - dly2_q;

        // Integrators run every clk; comb delays and the result move only on the tick.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                int1_q <= '0;
                int2_q <= '0;
                dly1_q <= '0;
                dly2_q <= '0;
                comb_q <= '0;
            end else begin
                int1_q <= int1_q + in_pm1;
                int2_q <= int2_q + int1_q;
                if (dec_tick) begin
                    dly1_q <= int2_q;
                    dly2_q <= comb1;
                    comb_q <= comb2;
                end
            end
        end

        // Sign-extend before shifting, so the full-scale positive result
        // can be seen and clamped instead of wrapping.
        assign comb_ext = {{(EXT_BW-W){comb_q[W-1]}}, comb_q};

        if (SHIFT >= 0) begin : g_shl
            assign scaled = comb_ext <<< SHIFT;
        end else begin : g_shr
            assign scaled = comb_ext >>> (-SHIFT);
        end

        // Saturate into the signed output range; the most negative code passes as-is.
        always_comb begin
            if (scaled > OUT_MAX) begin
                sample = OUT_MAX[SD_OUT_BW-1:0];
            end else if (scaled < OUT_MIN) begin
                sample = OUT_MIN[SD_OUT_BW-1:0];
            end else begin
                sample = scaled[SD_OUT_BW-1:0];
            end
        end

        assign sample_flat[gi*SD_OUT_BW +: SD_OUT_BW] = sample;
    end

    // ------------------------------------------------------------------
    // Output registers, zero-crossing detection and period measurement
    // ------------------------------------------------------------------
    logic signed [SD_OUT_BW-1:0] sample_a;
    logic signed [SD_OUT_BW-1:0] sample_b;
    logic signed [SD_OUT_BW-1:0] sample_c;

    logic signed [SD_OUT_BW-1:0] out_a_q;
    logic signed [SD_OUT_BW-1:0] out_b_q;
    logic signed [SD_OUT_BW-1:0] out_c_q;
    logic                        out_valid_q;
    logic                        period_valid_q;
    logic                        dir_fwd_q;
    logic                        prev_neg_q;
    logic                        armed_q;
    logic [PER_BW-1:0]           per_cnt_q;
    logic [PER_BW-1:0]           per_cnt_d;
    logic [PER_BW-1:0]           period_a_q;
    logic                        crossing;

    assign sample_a = sample_flat[0*SD_OUT_BW +: SD_OUT_BW];
    assign sample_b = sample_flat[1*SD_OUT_BW +: SD_OUT_BW];
    assign sample_c = sample_flat[2*SD_OUT_BW +: SD_OUT_BW];

    // The saturating increment also serves as the period value loaded at a
    // crossing, so a crossing sample is counted as part of its period.
    assign per_cnt_d = (&per_cnt_q) ? per_cnt_q : per_cnt_q + PER_BW'(1);

    // Rising crossing: the previous A sample was negative, the new one is not.
    assign crossing = prev_neg_q & ~sample_a[SD_OUT_BW-1];

    // Publish samples on the clk after a tick; the crossing logic works on the same sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_a_q        <= '0;
            out_b_q        <= '0;
            out_c_q        <= '0;
            out_valid_q    <= 1'b0;
            period_valid_q <= 1'b0;
            dir_fwd_q      <= 1'b0;
            prev_neg_q     <= 1'b0;
            armed_q        <= 1'b0;
            per_cnt_q      <= '0;
            period_a_q     <= '0;
        end else begin
            out_valid_q    <= tick_q;
            period_valid_q <= 1'b0;
            if (tick_q) begin
                out_a_q    <= sample_a;
                out_b_q    <= sample_b;
                out_c_q    <= sample_c;
                prev_neg_q <= sample_a[SD_OUT_BW-1];
                if (crossing) begin
                    // The first crossing after reset only arms the measurement.
                    per_cnt_q <= '0;
                    armed_q   <= 1'b1;
                    dir_fwd_q <= sample_b[SD_OUT_BW-1];
                    if (armed_q) begin
                        period_a_q     <= per_cnt_d;
                        period_valid_q <= 1'b1;
                    end
                end else begin
                    per_cnt_q <= per_cnt_d;
                end
            end
        end
    end

    assign outA         = out_a_q;
    assign outB         = out_b_q;
    assign outC         = out_c_q;
    assign out_valid    = out_valid_q;
    assign period_a     = period_a_q;
    assign period_valid = period_valid_q;
    assign dir_fwd      = dir_fwd_q;

endmodule

// File: tb/tb_sd_three_phase_decoder.sv
// Directed testbench for sd_three_phase_decoder (default parameters).
// The stimulus pushes expected samples and periods into queues. A monitor
// on the falling edge pops an entry whenever the DUT strobes a result and
// compares it.
module tb_sd_three_phase_decoder;
    localparam int SD_OUT_BW = 16;
    localparam int DEC_LOG2  = 6;
    localparam int PER_BW    = 16;
    localparam int R         = 2**DEC_LOG2;
    localparam int P         = 64*R;           // square-wave period in clks
    localparam int ROT_CYC   = 4*P + 1024;     // one arming crossing + three measured

    logic                        clk;
    logic                        rst;
    logic                        bsA, bsB, bsC;
    logic signed [SD_OUT_BW-1:0] outA, outB, outC;
    logic                        out_valid;
    logic [PER_BW-1:0]           period_a;
    logic                        period_valid;
    logic                        dir_fwd;

    sd_three_phase_decoder #(
        .SD_OUT_BW(SD_OUT_BW),
        .DEC_LOG2 (DEC_LOG2),
        .PER_BW   (PER_BW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bsA         (bsA),
        .bsB         (bsB),
        .bsC         (bsC),
        .outA        (outA),
        .outB        (outB),
        .outC        (outC),
        .out_valid   (out_valid),
        .period_a    (period_a),
        .period_valid(period_valid),
        .dir_fwd     (dir_fwd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit                          chk;
        logic signed [SD_OUT_BW-1:0] a;
        logic signed [SD_OUT_BW-1:0] b;
        logic signed [SD_OUT_BW-1:0] c;
    } samp_t;

    typedef struct {
        logic [PER_BW-1:0] per;
        logic              dir;
    } per_t;

    samp_t samp_q[$];
    per_t  per_q[$];
    int    checks    = 0;
    int    errors    = 0;
    int    pv_count  = 0;
    bit    samp_en   = 1'b0;
    samp_t mon_e;
    per_t  mon_p;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Square wave of period P, shifted by off/3 clks (off in units of 1/3 clk).
    function automatic logic sq(input int t, input int off);
        return ((3*t + off) % (3*P)) < (3*P/2);
    endfunction

    // Drive a rotating three-phase pattern. lat is the index of the first
    // posedge after which out_valid was seen (0 = never).
    task automatic drive_rotation(input bit fwd, input int ncyc, output int lat);
        lat = 0;
        for (int t = 0; t < ncyc; t++) begin
            bsA = sq(t, 0);
            bsB = fwd ? sq(t, 2*P) : sq(t, P);
            bsC = fwd ? sq(t, P)   : sq(t, 2*P);
            @(posedge clk);
            #1;
            if (out_valid && lat == 0) lat = t + 1;
        end
    endtask

    // Scoreboard monitor: compare each strobed result against the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && samp_en) begin
            checks++;
            assert (samp_q.size() != 0) else begin
                errors++;
                $error("FAIL samp_unexpected observed=out_valid expected=none");
            end
            if (samp_q.size() != 0) begin
                mon_e = samp_q.pop_front();
                if (mon_e.chk) begin
                    chk("outA", outA, mon_e.a);
                    chk("outB", outB, mon_e.b);
                    chk("outC", outC, mon_e.c);
                end
            end
        end
        if (!rst && period_valid) begin
            pv_count++;
            chk("pv_with_out_valid", out_valid, 1);
            checks++;
            assert (per_q.size() != 0) else begin
                errors++;
                $error("FAIL period_valid_unexpected observed=pulse expected=none period_a=%0d",
                       period_a);
            end
            if (per_q.size() != 0) begin
                mon_p = per_q.pop_front();
                chk("period_a", period_a, mon_p.per);
                chk("dir_fwd_at_crossing", dir_fwd, mon_p.dir);
            end
        end
    end

    initial begin
        samp_t e;
        per_t  p;
        int    lat;

        // ---- reset state ----
        rst = 1'b1;
        bsA = 1'b1; bsB = 1'b0; bsC = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outA", outA, 0);
        chk("rst_outB", outB, 0);
        chk("rst_outC", outC, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_period_a", period_a, 0);
        chk("rst_period_valid", period_valid, 0);
        chk("rst_dir_fwd", dir_fwd, 0);
        $display("step: reset state checked");

        // ---- constant / alternating bitstreams ----
        e.chk = 1'b0; e.a = '0; e.b = '0; e.c = '0;
        samp_q.push_back(e);
        samp_q.push_back(e);
        e.chk = 1'b1; e.a = 16'sh7FFF; e.b = 16'sh8000; e.c = 16'sh0000;
        repeat (4) samp_q.push_back(e);
        samp_en = 1'b1;
        rst = 1'b0;                       // released #1 after a posedge
        lat = 0;
        for (int n = 1; n <= 6*R + 1; n++) begin
            @(posedge clk);
            #1;
            if (out_valid && lat == 0) lat = n;
            bsC = ~bsC;
        end
        @(negedge clk);
        #1;
        samp_en = 1'b0;
        chk("first_valid_latency", lat, R + 1);
        chk("samp_q_drained", samp_q.size(), 0);
        $display("step: constant streams, %0d samples left unconsumed", samp_q.size());

        // ---- A-B-C rotation ----
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        p.per = PER_BW'(64); p.dir = 1'b1;
        repeat (3) per_q.push_back(p);
        drive_rotation(1'b1, ROT_CYC, lat);
        chk("fwd_per_q_drained", per_q.size(), 0);
        chk("fwd_pv_count", pv_count, 3);
        chk("fwd_dir_hold", dir_fwd, 1);
        $display("step: forward rotation, period_valid pulses=%0d", pv_count);

        // ---- reset mid-frame at decimation count R/2 ----
        repeat (R/2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_outA", outA, 0);
        chk("midrst_outB", outB, 0);
        chk("midrst_outC", outC, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_period_a", period_a, 0);
        chk("midrst_period_valid", period_valid, 0);
        chk("midrst_dir_fwd", dir_fwd, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("midrst_hold_out_valid", out_valid, 0);
        end
        rst = 1'b0;
        $display("step: mid-frame reset applied and released");

        // ---- A-C-B rotation; the first crossing after reset must stay silent ----
        p.per = PER_BW'(64); p.dir = 1'b0;
        repeat (3) per_q.push_back(p);
        drive_rotation(1'b0, ROT_CYC, lat);
        chk("midrst_first_valid_latency", lat, R + 1);
        chk("rev_per_q_drained", per_q.size(), 0);
        chk("rev_pv_count", pv_count, 6);
        chk("rev_dir_hold", dir_fwd, 0);
        $display("step: reverse rotation, period_valid pulses=%0d", pv_count);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
